// File: rtl/imm_gen_pkg.sv
// Opcodes, format codes and the buffered entry type shared by the
// immediate-generation stage (optional CSR-immediate decode: IMM_GEN_ZICSR_EN).
package imm_gen_pkg;

  localparam int IMM_MAX = 64;
  localparam int PC_MAX  = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  // Widest-case fields; the stage uses the low XLEN / PC_W bits.
  typedef struct packed {
    logic [IMM_MAX-1:0] imm;
    logic [2:0]         fmt;
    logic               illegal;
    logic [PC_MAX-1:0]  pc;
    logic [PC_MAX-1:0]  target;
  } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign extension to XLEN.
// CSR immediate forms decode only when IMM_GEN_ZICSR_EN is defined.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [31:0] imm32;
  logic        rv64;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic        is_z;
  logic        is_none;
  logic        unused_f3;

  assign opc       = instr[6:0];
  assign rv64      = (XLEN == 64);
  assign unused_f3 = ^instr[14:12];

  always_comb begin
    is_z = 1'b0;
`ifdef IMM_GEN_ZICSR_EN
    is_z = (opc == OP_SYSTEM) && instr[14];
`endif
    is_i = (opc == OP_LOAD) || (opc == OP_IMM) ||
           (opc == OP_JALR) ||
           (rv64 && (opc == OP_IMM32));
    is_s = (opc == OP_STORE);
    is_b = (opc == OP_BRANCH);
    is_u = (opc == OP_LUI) || (opc == OP_AUIPC);
    is_j = (opc == OP_JAL);
    is_none = (opc == OP_OP) ||
              (rv64 && (opc == OP_OP32)) ||
              (opc == OP_FENCE) ||
              ((opc == OP_SYSTEM) && !is_z);
  end

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
      end
      is_s: begin
        imm32 = {{20{instr[31]}}, instr[31:25],
                 instr[11:7]};
        fmt   = FMT_S;
      end
      is_b: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      is_u: begin
        imm32 = {instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      is_j: begin
        imm32 = {{11{instr[31]}}, instr[31],
                 instr[19:12], instr[20],
                 instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      is_z: begin
        imm32 = {27'b0, instr[19:15]};
        fmt   = FMT_Z;
      end
      is_none: fmt = FMT_NONE;
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// Optional CSR-immediate decode: define IMM_GEN_ZICSR_EN.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_target
);

  logic [XLEN-1:0] x_imm;
  logic [2:0]      x_fmt;
  logic            x_ill;
  logic [PC_W-1:0] x_tgt;

  imm_entry_t new_e;
  imm_entry_t main_d;
  imm_entry_t main_q;
  imm_entry_t skid_d;
  imm_entry_t skid_q;

  logic main_v_d;
  logic main_v_q;
  logic skid_v_d;
  logic skid_v_q;
  logic rdy_d;
  logic rdy_q;
  logic push;
  logic pop;
  logic unused_hi;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr  (in_instr),
    .imm    (x_imm),
    .fmt    (x_fmt),
    .illegal(x_ill)
  );

  assign x_tgt = in_pc + PC_W'($signed(x_imm));

  always_comb begin
    new_e         = '0;
    new_e.imm     = IMM_MAX'(x_imm);
    new_e.fmt     = x_fmt;
    new_e.illegal = x_ill;
    new_e.pc      = PC_MAX'(in_pc);
    new_e.target  = PC_MAX'(x_tgt);
  end

  assign push = in_valid && rdy_q;
  assign pop  = main_v_q && out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (pop) begin
      // skid full implies in_ready=0, so no push here
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (push) begin
        main_d   = new_e;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (push) begin
      if (!main_v_q) begin
        main_d   = new_e;
        main_v_d = 1'b1;
      end else begin
        skid_d   = new_e;
        skid_v_d = 1'b1;
      end
    end
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc[PC_W-1:0];
  assign out_target  = main_q.target[PC_W-1:0];

  assign unused_hi = ^{main_q.imm >> XLEN,
                       main_q.pc >> PC_W,
                       main_q.target >> PC_W};

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a 32-bit and a 64-bit instance
// driven from the same stimulus.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_pc;
  logic [31:0] out_target;

  logic        h_in_ready;
  logic        h_out_valid;
  logic [63:0] h_out_imm;
  logic [2:0]  h_out_fmt;
  logic        h_out_illegal;
  logic [31:0] h_out_pc;
  logic [31:0] h_out_target;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_JAL   = 32'h0080006F;
  localparam logic [31:0] I_ADD   = 32'h002081B3;

  imm_gen_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_pc(out_pc),
    .out_target(out_target)
  );

  imm_gen_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(h_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(h_out_valid), .out_ready(out_ready),
    .out_imm(h_out_imm), .out_fmt(h_out_fmt),
    .out_illegal(h_out_illegal), .out_pc(h_out_pc),
    .out_target(h_out_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins,
                      input logic [31:0] pc);
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input string tag,
                     input logic [31:0] ins,
                     input logic [31:0] pc,
                     input logic [31:0] imm,
                     input logic [2:0]  fmt,
                     input logic        ill,
                     input logic [31:0] tgt);
    push(ins, pc);
    check({tag, ".v"}, 64'(out_valid), 64'(1));
    check({tag, ".imm"}, 64'(out_imm), 64'(imm));
    check({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
    check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
    check({tag, ".pc"}, 64'(out_pc), 64'(pc));
    check({tag, ".tgt"}, 64'(out_target), 64'(tgt));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".rdy"}, 64'(in_ready), 64'(1));
    check({tag, ".v"}, 64'(out_valid), 64'(0));
    check({tag, ".imm"}, 64'(out_imm), 64'(0));
    check({tag, ".fmt"}, 64'(out_fmt), 64'(0));
    check({tag, ".ill"}, 64'(out_illegal), 64'(0));
    check({tag, ".pc"}, 64'(out_pc), 64'(0));
    check({tag, ".tgt"}, 64'(out_target), 64'(0));
    check({tag, ".v64"}, 64'(h_out_valid), 64'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    vec("addi", I_ADDI, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0, 32'hFF);
    check("addi.imm64", h_out_imm, 64'hFFFFFFFFFFFFFFFF);
    vec("beq", 32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h1FC);
    vec("jal", I_JAL, 32'h300, 32'h8, 3'd5, 1'b0, 32'h308);
    vec("sw", 32'hFE512C23, 32'h1000, 32'hFFFFFFF8, 3'd2, 1'b0, 32'hFF8);
    vec("lui", 32'h123452B7, 32'h0, 32'h12345000, 3'd4, 1'b0, 32'h12345000);
    check("lui.imm64", h_out_imm, 64'h0000000012345000);
    vec("luin", 32'hF23452B7, 32'h0, 32'hF2345000, 3'd4, 1'b0, 32'hF2345000);
    check("luin.imm64", h_out_imm, 64'hFFFFFFFFF2345000);
    check("luin.tgt64", 64'(h_out_target), 64'hF2345000);
    vec("add", I_ADD, 32'h700, 32'h0, 3'd0, 1'b0, 32'h700);
    vec("bad", 32'h0000007F, 32'h600, 32'h0, 3'd0, 1'b1, 32'h600);
    vec("addiw", 32'h0010809B, 32'h500, 32'h0, 3'd0, 1'b1, 32'h500);
    check("addiw.imm64", h_out_imm, 64'h1);
    check("addiw.fmt64", 64'(h_out_fmt), 64'(1));
    check("addiw.ill64", 64'(h_out_illegal), 64'(0));
    check("addiw.tgt64", 64'(h_out_target), 64'h501);
`ifdef IMM_GEN_ZICSR_EN
    vec("csr", 32'h3002D073, 32'h400, 32'h5, 3'd6, 1'b0, 32'h405);
`else
    vec("csr", 32'h3002D073, 32'h400, 32'h0, 3'd0, 1'b0, 32'h400);
`endif
    vec("wrap", I_ADDI, 32'h0, 32'hFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF);
    @(posedge clk);
    #1 check("drain.v", 64'(out_valid), 64'(0));

    out_ready = 1'b0;
    push(I_ADDI, 32'h10);
    check("bp.a.v", 64'(out_valid), 64'(1));
    check("bp.a.rdy", 64'(in_ready), 64'(1));
    push(I_JAL, 32'h20);
    check("bp.b.rdy", 64'(in_ready), 64'(0));
    check("bp.b.pc", 64'(out_pc), 64'h10);
    push(I_ADD, 32'h30);
    check("bp.hold.pc", 64'(out_pc), 64'h10);
    check("bp.hold.imm", 64'(out_imm), 64'hFFFFFFFF);
    check("bp.hold.rdy", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.pop.v", 64'(out_valid), 64'(1));
    check("bp.pop.pc", 64'(out_pc), 64'h20);
    check("bp.pop.imm", 64'(out_imm), 64'h8);
    check("bp.pop.rdy", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 check("bp.end.v", 64'(out_valid), 64'(0));

    out_ready = 1'b0;
    push(I_ADDI, 32'h40);
    push(I_JAL, 32'h50);
    check("fl.full.rdy", 64'(in_ready), 64'(0));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("fl.v", 64'(out_valid), 64'(0));
    check("fl.rdy", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    flush = 1'b1;
    push(I_ADDI, 32'h70);
    flush = 1'b0;
    check("fl.acc.v", 64'(out_valid), 64'(0));
    vec("fl.after", I_JAL, 32'h80, 32'h8, 3'd5, 1'b0, 32'h88);

    out_ready = 1'b0;
    push(I_ADDI, 32'h90);
    push(I_JAL, 32'hA0);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("rst_mid.idle", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage placed between the decode front-end and the ID/EX boundary.
- Generalises the combinational immediate generator:
  - XLEN-parametrised sign extension.
  - Emits a format code, an illegal-opcode flag and a precomputed PC-relative target.
  - Has a 2-entry skid buffer, so back-pressure never creates a combinational ready path.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended to XLEN.
- PC_W, 32, PC width carried alongside the instruction.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered output
- in_instr  in  32  raw instruction
- in_pc  in  PC_W  instruction address
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  format code (see package)
- out_illegal  out  1  opcode not recognised
- out_pc  out  PC_W  passthrough PC
- out_target  out  PC_W  out_pc + out_imm, truncated to PC_W

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, skid empty, in_ready=1. out_imm, out_fmt, out_pc and out_target are 0; out_illegal=0. A reset mid-transfer drops both entries with no partial output.
- Accept: an accept happens on in_valid && in_ready at a rising edge.
- Latency: exactly 1 cycle from accept to out_valid when downstream is not stalled.
- Extraction, by opcode:
  - I-type (0000011, 0010011, 1100111, and 0011011 only when XLEN=64): instr[31:20], sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]}, sign-extended.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - Register-register ops (0110011, and 0111011 only when XLEN=64), plus 0001111 and 1110011: imm=0, fmt=FMT_NONE, illegal=0.
  - Any other opcode: imm=0, fmt=FMT_NONE, illegal=1.
- Target: out_target = pc + imm computed in the input stage and registered. Wrap-around modulo 2^PC_W is accepted silently.
- Buffer control: a main output register plus one skid register. The skid register holds an accepted entry when the main register is valid and out_ready=0.
  - in_ready (registered) = skid empty.
  - Pop when out_valid && out_ready; the skid entry moves to main the same edge.
  - Simultaneous push and pop with skid empty: the new entry goes to main.
  - Simultaneous push and pop with skid full: cannot occur, because in_ready=0.
- Data stability: output payload is held stable while out_valid && !out_ready.
- Flush: flush=1 clears the main and skid valid bits at the next edge and has priority over a same-cycle accept, so that entry is discarded. in_ready=1 the cycle after a flush.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSR immediate forms) yields imm = zero-extended instr[19:15], fmt=FMT_Z, illegal=0.
- Undefined: opcode 1110011 always yields imm=0 and fmt=FMT_NONE.

Decomposition:
- Package imm_gen_pkg holds:
  - Opcode constants.
  - Format codes: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6.
  - Struct imm_entry_t = {imm, fmt, illegal, pc, target}.
- Sub-module imm_extract: purely combinational instr -> {imm, fmt, illegal}, parametrised on XLEN. The top holds the adder and the skid/valid control.

Test Plan:
- addi 0xFFF00093, pc 0x100, out_ready=1 -> one cycle later: out_imm=0xFFFFFFFF, fmt=1, illegal=0, target=0xFF.
- beq 0xFE000EE3, pc 0x200 -> imm=0xFFFFFFFC, fmt=3, target=0x1FC.
- jal 0x0080006F, pc 0x300 -> imm=8, fmt=5, target=0x308.
- lui 0x123452B7 with XLEN=64 -> imm=0x0000000012345000. With 0xF23452B7 -> imm=0xFFFFFFFFF2345000.
- Back-pressure: push A and B while out_ready=0 -> in_ready=0 after B. Raise out_ready -> A then B delivered in order, no loss or duplication. Assert flush with B in skid -> out_valid=0 next cycle.
- csrrwi 0x3002D073 -> imm=5 and fmt=6 with IMM_GEN_ZICSR_EN; imm=0 and fmt=0 without it. Opcode 0x7F -> illegal=1.
